// File: rtl/ecall_pkg.sv
// ecall_pkg: syscall codes, console FSM states and the hex-digit helper
//   SYS_EXIT / SYS_PUTC / SYS_PUTHEX : values of a0 selecting the call
//   state_t                          : console FSM states
//   nibble_to_ascii                  : 4-bit value -> uppercase ASCII hex digit
package ecall_pkg;

    localparam logic [31:0] SYS_EXIT   = 32'd0;
    localparam logic [31:0] SYS_PUTC   = 32'd1;
    localparam logic [31:0] SYS_PUTHEX = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEX,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/ecall_uart_tx.sv
// ecall_uart_tx: 8N1 serializer, LSB first, line idles high
//   clk, reset : clock, asynchronous active-low reset
//   i_data     : byte to send
//   i_valid    : i_data is available
//   o_ready    : serializer idle; o_ready && i_valid loads i_data at the edge
//   o_tx       : serial line
module ecall_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic          r_busy;
    logic [9:0]    r_shift;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_clk;
    logic          w_bit_end;

    assign w_bit_end = r_clk == CW'(CLKS_PER_BIT - 1);
    assign o_ready   = !r_busy;
    // ones are shifted in behind the frame, so the line is already high
    // when the stop bit ends; reset forces it high without waiting for clk
    assign o_tx      = !r_busy || r_shift[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_shift <= '1;
            r_bit   <= '0;
            r_clk   <= '0;
        end else if (!r_busy) begin
            if (i_valid) begin
                r_busy  <= 1'b1;
                r_shift <= {1'b1, i_data, 1'b0};
                r_bit   <= '0;
                r_clk   <= '0;
            end
        end else if (w_bit_end) begin
            r_clk   <= '0;
            r_shift <= {1'b1, r_shift[9:1]};
            r_bit   <= r_bit + 4'd1;
            r_busy  <= r_bit != 4'd9;
        end else begin
            r_clk <= r_clk + 1'b1;
        end
    end

endmodule

// File: rtl/ecall_console.sv
// ecall_console: ECALL handler (exit / putc / puthex) with byte FIFO and UART TX
//   clk, reset     : clock, asynchronous active-low reset
//   ecall_sig      : current instruction is ECALL
//   reg_a0, reg_a1 : syscall code and argument
//   stall          : hold PC and suppress writeback this cycle
//   halt           : program exited, sticky until reset
//   exit_code      : a1 captured by the exit call
//   uart_tx        : serial console output
module ecall_console
    import ecall_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall_sig,
    input  logic [31:0] reg_a0,
    input  logic [31:0] reg_a1,
    output logic        stall,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        uart_tx
);

    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [31:0] r_hex;
    logic [2:0]  r_cnt;
    logic [31:0] r_exit;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_ready;
    logic [7:0]  w_byte;

    assign w_empty   = r_wptr == r_rptr;
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = w_ready && !w_empty;
    assign halt      = r_state == ST_HALTED;
    assign exit_code = r_exit;

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        w_push = 1'b0;
        w_byte = reg_a1[7:0];
        case (r_state)
            ST_IDLE: begin
                if (ecall_sig && reg_a0 == SYS_PUTC) begin
                    w_push = !w_full;
                    stall  = w_full;
                end else if (ecall_sig && reg_a0 == SYS_PUTHEX) begin
                    stall  = 1'b1;
                    w_next = ST_HEX;
                end else if (ecall_sig && reg_a0 == SYS_EXIT) begin
                    stall  = 1'b1;
                    w_next = ST_DRAIN;
                end
            end
            ST_HEX: begin
                // the cycle pushing the last digit retires the ECALL
                w_byte = nibble_to_ascii(r_hex[31:28]);
                w_push = !w_full;
                stall  = !(r_cnt == 3'd7 && !w_full);
                w_next = (r_cnt == 3'd7 && !w_full) ? ST_IDLE : ST_HEX;
            end
            ST_DRAIN: begin
                stall  = 1'b1;
                w_next = (w_empty && w_ready) ? ST_HALTED : ST_DRAIN;
            end
            default: stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_hex  <= '0;
            r_cnt  <= '0;
            r_exit <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (r_state == ST_IDLE && ecall_sig && reg_a0 == SYS_PUTHEX) begin
                r_hex <= reg_a1;
                r_cnt <= '0;
            end else if (r_state == ST_HEX && w_push) begin
                r_hex <= r_hex << 4;
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_state == ST_IDLE && ecall_sig && reg_a0 == SYS_EXIT) r_exit <= reg_a1;
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_byte;
    end

    ecall_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .i_data (r_mem[r_rptr[AW-1:0]]),
        .i_valid(!w_empty),
        .o_ready(w_ready),
        .o_tx   (uart_tx)
    );

endmodule
